mmm_acc_engine: RTL

//  Pipelined mixed-precision matrix-multiply-accumulate engine.

---
 rtl/mmm_acc_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mmm_acc_engine.sv
// rtl/mmm_acc_engine.sv - pipelined mixed-precision matrix-multiply-accumulate engine
// Optional clamping accumulate and out_sat reporting: define MMM_ACC_SAT_EN.
module mmm_acc_engine #(
  parameter int DIM1      = 2,
  parameter int DIM2      = 2,
  parameter int DIM3      = 4,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 4,
  parameter int ACC_WIDTH = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [1:0]                                mode,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      in_first,
  input  logic                                      in_last,
  input  logic [DIM3-1:0][DIM1-1:0][A_WIDTH-1:0]    in_a,
  input  logic [DIM3-1:0][DIM2-1:0][B_WIDTH-1:0]    in_b,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [DIM1-1:0][DIM2-1:0][ACC_WIDTH-1:0]  out_c,
  output logic [CNT_WIDTH-1:0]                      out_count,
  output logic                                      out_sat,
  output logic                                      err_proto
);
  localparam int LVLS = $clog2(DIM3);
  localparam int PW   = A_WIDTH + B_WIDTH + 1;
  localparam int SW   = PW + LVLS;
  localparam int AW1  = ACC_WIDTH + 1;

  if (ACC_WIDTH < SW) begin : g_width_check
    $error("mmm_acc_engine: ACC_WIDTH must be at least A_WIDTH+B_WIDTH+1+clog2(DIM3)");
  end

  typedef enum logic {S_IDLE, S_OPEN} state_t;
  state_t state, state_nxt;
  logic   stall, accept, eff_first, proto_bad;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (accept) state_nxt = in_last ? S_IDLE : S_OPEN;
  end

  // A beat arriving with no open sequence always starts one, first flag or not.
  always_comb begin
    eff_first = in_first | (state == S_IDLE);
    proto_bad = accept & ((state == S_IDLE) ? ~in_first : in_first);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)         err_proto <= 1'b0;
    else if (proto_bad) err_proto <= 1'b1;
  end

  function automatic logic signed [SW-1:0] mul(input logic [A_WIDTH-1:0] a,
                                               input logic [B_WIDTH-1:0] b,
                                               input logic [1:0]         m);
    logic signed [PW-1:0] ax, bx, p;
    ax = {{(PW-A_WIDTH){m[0] & a[A_WIDTH-1]}}, a};
    bx = {{(PW-B_WIDTH){m[1] & b[B_WIDTH-1]}}, b};
    p  = ax * bx;
    return SW'(p);
  endfunction

  logic [LVLS:0]        vld, fst, lst;
  logic signed [SW-1:0] tree [LVLS+1][DIM1][DIM2][DIM3];

  // Level 0 holds products; level l holds DIM3>>l partial sums, the rest stay zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      fst <= '0;
      lst <= '0;
      for (int l = 0; l <= LVLS; l++)
        for (int i = 0; i < DIM1; i++)
          for (int j = 0; j < DIM2; j++)
            for (int k = 0; k < DIM3; k++)
              tree[l][i][j][k] <= '0;
    end else if (!stall) begin
      vld <= {vld[LVLS-1:0], accept};
      fst <= {fst[LVLS-1:0], eff_first};
      lst <= {lst[LVLS-1:0], in_last};
      for (int i = 0; i < DIM1; i++)
        for (int j = 0; j < DIM2; j++) begin
          for (int k = 0; k < DIM3; k++)
            tree[0][i][j][k] <= mul(in_a[k][i], in_b[k][j], mode);
          for (int l = 1; l <= LVLS; l++)
            for (int k = 0; k < (DIM3 >> l); k++)
              tree[l][i][j][k] <= tree[l-1][i][j][2*k] + tree[l-1][i][j][2*k+1];
        end
    end
  end

  logic signed [ACC_WIDTH-1:0] acc     [DIM1][DIM2];
  logic signed [ACC_WIDTH-1:0] acc_nxt [DIM1][DIM2];
  logic [CNT_WIDTH-1:0]        cnt, cnt_nxt;

`ifdef MMM_ACC_SAT_EN
  logic signed [ACC_WIDTH:0] wide [DIM1][DIM2];
  logic                      clamp_any, seq_sat, seq_sat_nxt;

  always_comb begin
    clamp_any = 1'b0;
    for (int i = 0; i < DIM1; i++)
      for (int j = 0; j < DIM2; j++) begin
        wide[i][j]    = AW1'(acc[i][j]) + AW1'(tree[LVLS][i][j][0]);
        acc_nxt[i][j] = ACC_WIDTH'(tree[LVLS][i][j][0]);
        if (!fst[LVLS]) begin
          if (wide[i][j][ACC_WIDTH] != wide[i][j][ACC_WIDTH-1]) begin
            acc_nxt[i][j] = wide[i][j][ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                  : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            clamp_any     = 1'b1;
          end else begin
            acc_nxt[i][j] = wide[i][j][ACC_WIDTH-1:0];
          end
        end
      end
    seq_sat_nxt = (fst[LVLS] ? 1'b0 : seq_sat) | clamp_any;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_sat <= 1'b0;
      out_sat <= 1'b0;
    end else if (!stall && vld[LVLS]) begin
      seq_sat <= seq_sat_nxt;
      if (lst[LVLS]) out_sat <= seq_sat_nxt;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < DIM1; i++)
      for (int j = 0; j < DIM2; j++) begin
        acc_nxt[i][j] = ACC_WIDTH'(tree[LVLS][i][j][0]);
        if (!fst[LVLS]) acc_nxt[i][j] = acc[i][j] + acc_nxt[i][j];
      end
  end

  assign out_sat = 1'b0;
`endif

  always_comb begin
    cnt_nxt = CNT_WIDTH'(1);
    if (!fst[LVLS]) cnt_nxt = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_c     <= '0;
      out_count <= '0;
      for (int i = 0; i < DIM1; i++)
        for (int j = 0; j < DIM2; j++)
          acc[i][j] <= '0;
    end else if (!stall) begin
      out_valid <= vld[LVLS] & lst[LVLS];
      if (vld[LVLS]) begin
        cnt <= cnt_nxt;
        for (int i = 0; i < DIM1; i++)
          for (int j = 0; j < DIM2; j++)
            acc[i][j] <= acc_nxt[i][j];
        if (lst[LVLS]) begin
          out_count <= cnt_nxt;
          for (int i = 0; i < DIM1; i++)
            for (int j = 0; j < DIM2; j++)
              out_c[i][j] <= acc_nxt[i][j];
        end
      end
    end
  end
endmodule
